// File: rtl/bcd_timer_ctrl.sv
// BCD hh:mm:ss timer with an on-chip tick prescaler. It counts down (countdown)
// or up (stopwatch), supports a synchronous preset with a reload shadow, and has
// optional auto-reload on down-count expiry. Everything runs on CP; there are no
// derived clocks.
//
// Ports:
//   CP         clock, rising edge
//   CR         asynchronous active-low reset, clears all state
//   CE         run enable (low pauses time and prescaler)
//   PE         synchronous preset of time and reload shadow from D_*
//   UP         1 = count up, 0 = count down (sampled every tick)
//   RELOAD_EN  down mode: reload the shadow on expiry and keep running
//   D_H/M/S    preset value, BCD
//   Q_H/M/S    current time, BCD
//   TC         one-cycle pulse when the terminal value is reached
//   DONE       sticky expiry flag
//   RUNNING    high while in the run state
module bcd_timer_ctrl #(
  parameter int unsigned CLK_DIV  = 1000,
  parameter logic [7:0]  HOUR_MAX = 8'h23,
  parameter int unsigned DIV_W    = $clog2(CLK_DIV) + 1
) (
  input  logic       CP,
  input  logic       CR,
  input  logic       CE,
  input  logic       PE,
  input  logic       UP,
  input  logic       RELOAD_EN,
  input  logic [7:0] D_H,
  input  logic [7:0] D_M,
  input  logic [7:0] D_S,
  output logic [7:0] Q_H,
  output logic [7:0] Q_M,
  output logic [7:0] Q_S,
  output logic       TC,
  output logic       DONE,
  output logic       RUNNING
);

  localparam logic [DIV_W-1:0] PrescLast = DIV_W'(CLK_DIV - 1);

  typedef enum logic [1:0] {StIdle, StRun, StPause, StExpired} state_e;

  // Force each nibble into 0..9, then clamp the whole byte to max.
  function automatic logic [7:0] sanitize(input logic [7:0] v, input logic [7:0] max);
    logic [3:0] hi, lo;
    logic [7:0] c;
    hi = (v[7:4] > 4'd9) ? 4'd9 : v[7:4];
    lo = (v[3:0] > 4'd9) ? 4'd9 : v[3:0];
    c  = {hi, lo};
    return (c > max) ? max : c;
  endfunction

  // Returns {carry, next} for a 00..59 field.
  function automatic logic [8:0] inc_base60(input logic [7:0] v);
    logic [3:0] hi, lo;
    hi = v[7:4] + 4'd1;
    lo = v[3:0] + 4'd1;
    if (v >= 8'h59)          return {1'b1, 8'h00};
    else if (v[3:0] == 4'd9) return {1'b0, hi, 4'h0};
    else                     return {1'b0, v[7:4], lo};
  endfunction

  // Returns {borrow, next} for a 00..59 field.
  function automatic logic [8:0] dec_base60(input logic [7:0] v);
    logic [3:0] hi, lo;
    hi = v[7:4] - 4'd1;
    lo = v[3:0] - 4'd1;
    if (v == 8'h00)          return {1'b1, 8'h59};
    else if (v[3:0] == 4'd0) return {1'b0, hi, 4'h9};
    else                     return {1'b0, v[7:4], lo};
  endfunction

  // Hours saturate at both ends; the terminal check keeps them from being hit.
  function automatic logic [7:0] inc_hour(input logic [7:0] v);
    logic [3:0] hi, lo;
    hi = v[7:4] + 4'd1;
    lo = v[3:0] + 4'd1;
    if (v >= HOUR_MAX)       return v;
    else if (v[3:0] == 4'd9) return {hi, 4'h0};
    else                     return {v[7:4], lo};
  endfunction

  function automatic logic [7:0] dec_hour(input logic [7:0] v);
    logic [3:0] hi, lo;
    hi = v[7:4] - 4'd1;
    lo = v[3:0] - 4'd1;
    if (v == 8'h00)          return v;
    else if (v[3:0] == 4'd0) return {hi, 4'h9};
    else                     return {v[7:4], lo};
  endfunction

  function automatic logic is_terminal(input logic up, input logic [7:0] h,
                                       input logic [7:0] m, input logic [7:0] s);
    if (up) return (h == HOUR_MAX) && (m == 8'h59) && (s == 8'h59);
    else    return (h == 8'h00) && (m == 8'h00) && (s == 8'h00);
  endfunction

  state_e           state_q, state_d;
  logic [7:0]       h_q, h_d, m_q, m_d, s_q, s_d;
  logic [7:0]       sh_h_q, sh_h_d, sh_m_q, sh_m_d, sh_s_q, sh_s_d;
  logic [DIV_W-1:0] presc_q, presc_d;
  logic             tc_q, tc_d, done_q, done_d;
  // Set when a tick reached 00:00:00 with reload active; the next tick then
  // loads the shadow instead of expiring.
  logic             armed_q, armed_d;

  logic [8:0] s_step, m_step;
  logic [7:0] h_step, nxt_h, nxt_m, nxt_s;
  logic       cur_term, nxt_term, reload_ok;

  assign s_step = UP ? inc_base60(s_q) : dec_base60(s_q);
  assign m_step = UP ? inc_base60(m_q) : dec_base60(m_q);
  assign h_step = UP ? inc_hour(h_q) : dec_hour(h_q);

  assign nxt_s = s_step[7:0];
  assign nxt_m = s_step[8] ? m_step[7:0] : m_q;
  assign nxt_h = (s_step[8] && m_step[8]) ? h_step : h_q;

  assign cur_term  = is_terminal(UP, h_q, m_q, s_q);
  assign nxt_term  = is_terminal(UP, nxt_h, nxt_m, nxt_s);
  // A zero shadow would re-expire forever, so treat it as no reload.
  assign reload_ok = !UP && RELOAD_EN && (|{sh_h_q, sh_m_q, sh_s_q});

  always_comb begin
    state_d = state_q;
    h_d     = h_q;
    m_d     = m_q;
    s_d     = s_q;
    sh_h_d  = sh_h_q;
    sh_m_d  = sh_m_q;
    sh_s_d  = sh_s_q;
    presc_d = presc_q;
    tc_d    = 1'b0;
    done_d  = done_q;
    armed_d = armed_q;

    if (PE) begin
      h_d     = sanitize(D_H, HOUR_MAX);
      m_d     = sanitize(D_M, 8'h59);
      s_d     = sanitize(D_S, 8'h59);
      sh_h_d  = h_d;
      sh_m_d  = m_d;
      sh_s_d  = s_d;
      presc_d = '0;
      done_d  = 1'b0;
      armed_d = 1'b0;
      state_d = CE ? StRun : StIdle;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (CE) state_d = StRun;
        end
        StRun: begin
          if (!CE) begin
            state_d = StPause;
          end else if (cur_term && !armed_q) begin
            // Entered run already at the terminal value: expire without a tick.
            tc_d    = 1'b1;
            done_d  = 1'b1;
            state_d = StExpired;
          end else if (cur_term && !reload_ok) begin
            // Reload was withdrawn while waiting; TC has already been issued.
            armed_d = 1'b0;
            state_d = StExpired;
          end else if (presc_q == PrescLast) begin
            presc_d = '0;
            armed_d = 1'b0;
            if (cur_term) begin
              h_d = sh_h_q;
              m_d = sh_m_q;
              s_d = sh_s_q;
            end else begin
              h_d = nxt_h;
              m_d = nxt_m;
              s_d = nxt_s;
              if (nxt_term) begin
                tc_d   = 1'b1;
                done_d = 1'b1;
                if (reload_ok) armed_d = 1'b1;
                else           state_d = StExpired;
              end
            end
          end else begin
            presc_d = presc_q + DIV_W'(1);
          end
        end
        StPause: begin
          if (CE) state_d = StRun;
        end
        StExpired: begin
          done_d = 1'b1;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge CP or negedge CR) begin
    if (!CR) begin
      state_q <= StIdle;
      h_q     <= '0;
      m_q     <= '0;
      s_q     <= '0;
      sh_h_q  <= '0;
      sh_m_q  <= '0;
      sh_s_q  <= '0;
      presc_q <= '0;
      tc_q    <= 1'b0;
      done_q  <= 1'b0;
      armed_q <= 1'b0;
    end else begin
      state_q <= state_d;
      h_q     <= h_d;
      m_q     <= m_d;
      s_q     <= s_d;
      sh_h_q  <= sh_h_d;
      sh_m_q  <= sh_m_d;
      sh_s_q  <= sh_s_d;
      presc_q <= presc_d;
      tc_q    <= tc_d;
      done_q  <= done_d;
      armed_q <= armed_d;
    end
  end

  assign Q_H     = h_q;
  assign Q_M     = m_q;
  assign Q_S     = s_q;
  assign TC      = tc_q;
  assign DONE    = done_q;
  assign RUNNING = (state_q == StRun);

endmodule

// File: doc/bcd_timer_ctrl.md
Name: bcd_timer_ctrl

Overview:
- Parametrised single-clock BCD hh:mm:ss timer: down-count (countdown) or up-count (stopwatch), with built-in tick prescaler, synchronous preset, optional auto-reload, terminal pulse and sticky done flag.
- Successor to the three-cascade countdown: no derived or ripple clocks; all state is in the CP domain.
- Sits between the keypad/preset logic (D_*, PE, CE) and the 7-segment display driver (Q_*) and the alarm logic (TC, DONE).

Parameters:
- CLK_DIV, 1000, CP cycles per one-second tick (≥1; 1 means every enabled cycle is a tick).
- HOUR_MAX, 8'h23, BCD maximum hour value (8'h23 or 8'h99).
- DIV_W, $clog2(CLK_DIV)+1, prescaler counter width (derived).

Ports:
- CP  in  1  clock, rising edge.
- CR  in  1  reset: asynchronous, active-low; clears all state.
- CE  in  1  run enable: high counts, low pauses (holds time and prescaler).
- PE  in  1  synchronous preset: loads D_* into time and into the reload shadow.
- UP  in  1  mode: 1 = count up, 0 = count down; sampled on every tick.
- RELOAD_EN  in  1  down mode only: on expiry, reload the shadow and keep running.
- D_H  in  8  preset hours, BCD.
- D_M  in  8  preset minutes, BCD.
- D_S  in  8  preset seconds, BCD.
- Q_H  out  8  current hours, BCD.
- Q_M  out  8  current minutes, BCD.
- Q_S  out  8  current seconds, BCD.
- TC  out  1  one-cycle pulse on reaching the terminal value.
- DONE  out  1  sticky expiry flag.
- RUNNING  out  1  high in state RUN.

Behaviour:
- Reset (CR=0, async): Q_*=0, shadow=0, prescaler=0, TC=0, DONE=0, RUNNING=0, state=IDLE.
- Priority each CP edge: CR > PE > terminal check > tick.
- Preset sanitisation:
  - any nibble > 9 is forced to 9;
  - D_M/D_S above 8'h59 are forced to 8'h59;
  - D_H above HOUR_MAX is forced to HOUR_MAX.
  - The sanitised value goes to Q_* and the shadow.
- PE effects: clears DONE and the prescaler. Next state is RUN if CE=1, otherwise IDLE.
- Terminal value: 00:00:00 when UP=0; HOUR_MAX:59:59 when UP=1.
- States:
  - IDLE: holds; CE=1 moves to RUN.
  - RUN: prescaler increments each cycle while CE=1. CE=0 moves to PAUSE with the prescaler held.
  - PAUSE: CE=1 returns to RUN and resumes the prescaler from its held value.
  - EXPIRED: DONE=1, time holds. Leaves only on PE or CR.
- Tick: asserted when prescaler = CLK_DIV-1 in RUN; the prescaler then wraps to 0. Time changes exactly once per tick; latency from tick to Q_* change is 1 cycle (registered).
- Down count (UP=0):
  - Ones digit decrements; at 0 it wraps to 9 and borrows.
  - Seconds/minutes wrap 00 to 59 and borrow.
  - Hours never underflow, because the terminal check precedes the tick.
- Up count (UP=1):
  - Ones digit 9 wraps to 0 with carry.
  - Seconds/minutes wrap 59 to 00 with carry.
- Expiry, when the tick produces the terminal value:
  - TC=1 for exactly one cycle, in the cycle Q_* first shows the terminal value.
  - If UP=0 and RELOAD_EN=1: on the next tick Q_* loads the shadow instead of decrementing; the state stays RUN; DONE is set and stays sticky.
  - Otherwise: state goes to EXPIRED and DONE=1 in the same cycle as TC.
- Entering RUN while Q_* is already terminal (e.g. preset 00:00:00 down): one-cycle TC and DONE=1 on the first RUN cycle. No tick is consumed and the value is not reloaded.
- UP changed mid-run: takes effect at the next tick; no TC unless the terminal value for the new mode is reached by a tick.
- Shadow = 00:00:00 with RELOAD_EN=1, down mode: behaves as if RELOAD_EN=0 (goes to EXPIRED, no endless TC).
- PE during RUN: reload takes effect at the next edge; TC is suppressed that cycle; the prescaler restarts.
- CR deasserted mid-tick: no partial update; all state is zero after reset.

Test Plan:
- CLK_DIV=4, preset 00:01:00 down, CE=1 → Q_S=59 after 4 cycles, Q_M=00; 00:00:00 at tick 60; TC high one cycle; DONE=1; state EXPIRED.
- CLK_DIV=1, preset 01:00:00 down → next tick 00:59:59; up mode preset 00:59:59 → 01:00:00; HOUR_MAX=8'h23 up at 23:59:58 → TC when 23:59:59, then hold.
- RELOAD_EN=1, preset 00:00:02, CLK_DIV=1 → sequence 02,01,00(TC),02,01,00(TC); DONE stays 1; RUNNING stays 1.
- CE dropped at prescaler=2 (CLK_DIV=4) for 10 cycles → Q_* and prescaler frozen; tick occurs 2 cycles after CE returns.
- Preset D_H=8'h3A, D_M=8'h75, D_S=8'h59 with HOUR_MAX=8'h23 → Q=23:59:59. Preset 00:00:00 down, CE=1 → TC one cycle, DONE=1.
- CR low mid-count (async, between edges) → all outputs 0 immediately; PE asserted in the same cycle as expiry → load wins, TC=0, DONE=0.
